timeout_sched: RTL and testbench
================================

# timeout_sched

Shared timeout scheduler: arbitrates N requesters for a single W-bit countdown timer, loads the winner's timeout value, and returns a one-cycle expiry pulse to that requester when its timeout elapses. It sits between protocol engines that each need occasional timeouts (retry, watchdog, bus idle) and the timer datapath, so the design needs one counter instead of N.

## Interface
- N, 4: number of requesters, 2..16
- W, 8: timeout value / counter width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset == 0 at a rising edge resets the block
- req  in  N  request per channel; held high until ack is seen
- value  in  N*W  per-channel timeout, channel i at bits [i*W +: W]; sampled only at grant
- ack  out  N  one-hot, one-cycle pulse: request accepted, timer loaded
- expire  out  N  one-hot, one-cycle pulse: owner's timeout elapsed
- busy  out  1  timer owned (state RUN)
- owner  out  clog2(N)  index of current or last owner
- count  out  W  current counter value
- cancel  in  N  per-channel abort (only with TIMEOUT_SCHED_CANCEL_EN)

## Operation
- States: IDLE, RUN. Encoding: IDLE=0, RUN=1.
- IDLE: at an edge with any req bit high, the round-robin arbiter picks g; state←RUN, owner←g, count←value[g], ack[g]←1, pointer←g+1 (mod N). No req: stay IDLE.
- RUN: count != 0 → count←count-1. count == 0 → expire[owner]←1, state←IDLE.
- Round-robin: search starts at pointer and wraps; after reset pointer=0, so channel 0 has highest priority.
- No arbitration in RUN; req bits wait. A req still high after expire is granted again (re-arm).
- value sampled once at grant; later changes ignored.
- value = 0 is legal: expire follows grant by one cycle.
- All outputs registered; ack and expire are one-hot or zero, never both nonzero in the same cycle.

## Timing
- Reset values: ack=0, expire=0, busy=0, owner=0, count=0, state IDLE, pointer=0.
- Grant at edge k: ack[g] and busy high in cycle k..k+1. Expire pulse in the cycle after edge k+V+1, i.e. V+1 cycles after ack.
- After expire, state is IDLE for at least one cycle. Earliest next ack is one edge after the expire edge, so back-to-back timeouts cost V+2 cycles each.
- Reset low mid-RUN: state IDLE, count 0, no expire issued, pending grant lost; requesters re-request.
- Simultaneous requests: exactly one ack per grant; the others wait in round-robin order.

## Configuration
- TIMEOUT_SCHED_CANCEL_EN defined: cancel port present.
  - In RUN, cancel[owner] high at an edge → state←IDLE, count←0, no expire.
  - cancel of non-owners ignored.
  - cancel[owner] at the same edge as count == 0 → expire wins.
- Undefined: no cancel port; every granted timeout runs to expiry.

## Structure
- Shared package/header (timer/): state encoding constants, clog2 function for owner width.
- One natural sub-module: rr_arbiter (N-bit req, pointer in, one-hot grant and index out, combinational).
- Counter and FSM inline in timeout_sched.

## Test plan
- Single request: N=4, W=8, req[2]=1, value[2]=5 → ack[2] one cycle, expire[2] exactly 6 cycles after ack, busy low the cycle after.
- value=0 on channel 1 → expire[1] one cycle after ack[1].
- req=4'b1111 held, all values 3 → acks in order 0,1,2,3,0; each expire 4 cycles after its ack; each next ack 1 cycle after the previous expire.
- Reset low 2 cycles into a value=10 run → all outputs return to reset values, no expire ever seen for that grant.
- CANCEL_EN: value=10, cancel[owner] 3 cycles after ack → no expire, busy low next cycle. cancel[owner] on the count==0 edge → expire still pulses.
- value[i] changed while RUN → expire timing still follows the value sampled at grant.

Source files
------------

// File: rtl/timeout_sched_pkg.sv
// Shared types and helpers for the timeout scheduler.
// State encoding and the owner-index width function.
package timeout_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/timeout_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_ptr and wraps.
// Produces a one-hot grant, its index, and a valid flag.
module rr_arbiter
  import timeout_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2_f(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int w_c;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_c     = 0;
    for (int k = 0; k < N; k++) begin
      w_c = (int'(i_ptr) + k) % N;
      if (!o_valid && i_req[w_c]) begin
        o_valid     = 1'b1;
        o_grant[w_c] = 1'b1;
        o_idx       = w_c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/timeout_sched.sv
// Shared timeout scheduler: one countdown timer arbitrated among N requesters.
// Optional owner abort via TIMEOUT_SCHED_CANCEL_EN.
module timeout_sched
  import timeout_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IW = clog2_f(N)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N-1:0]   i_req,
  input  logic [N*W-1:0] i_value,
`ifdef TIMEOUT_SCHED_CANCEL_EN
  input  logic [N-1:0]   i_cancel,
`endif
  output logic [N-1:0]   o_ack,
  output logic [N-1:0]   o_expire,
  output logic           o_busy,
  output logic [IW-1:0]  o_owner,
  output logic [W-1:0]   o_count
);

  state_e        r_state;
  logic [W-1:0]  r_count;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  r_ack;
  logic [N-1:0]  r_expire;

  state_e        w_state_n;
  logic [W-1:0]  w_count_n;
  logic [IW-1:0] w_owner_n;
  logic [IW-1:0] w_ptr_n;
  logic [N-1:0]  w_ack_n;
  logic [N-1:0]  w_expire_n;

  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_valid;

  rr_arbiter #(.N(N)) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_ack    <= '0;
      r_expire <= '0;
    end else begin
      r_state  <= w_state_n;
      r_count  <= w_count_n;
      r_owner  <= w_owner_n;
      r_ptr    <= w_ptr_n;
      r_ack    <= w_ack_n;
      r_expire <= w_expire_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_count_n  = r_count;
    w_owner_n  = r_owner;
    w_ptr_n    = r_ptr;
    w_ack_n    = '0;
    w_expire_n = '0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_n = RUN;
          w_owner_n = w_idx;
          w_count_n = i_value[int'(w_idx)*W +: W];
          w_ack_n   = w_grant;
          w_ptr_n   = (w_idx == IW'(N-1)) ? '0 : w_idx + 1'b1;
        end
      end
      RUN: begin
        // expiry takes precedence over an abort on the same edge
        if (r_count == '0) begin
          w_expire_n[r_owner] = 1'b1;
          w_state_n           = IDLE;
`ifdef TIMEOUT_SCHED_CANCEL_EN
        end else if (i_cancel[r_owner]) begin
          w_state_n = IDLE;
          w_count_n = '0;
`endif
        end else begin
          w_count_n = r_count - 1'b1;
        end
      end
    endcase
  end

  assign o_ack    = r_ack;
  assign o_expire = r_expire;
  assign o_busy   = (r_state == RUN);
  assign o_owner  = r_owner;
  assign o_count  = r_count;

endmodule

// File: tb/tb_timeout_sched.sv
// Self-checking bench for timeout_sched: directed scenarios plus
// randomized traffic against a deadline-based reference model.
module tb_timeout_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] value = '0;
  logic [N-1:0]   cancel = '0;
  logic [N-1:0]   o_ack;
  logic [N-1:0]   o_expire;
  logic           o_busy;
  logic [1:0]     o_owner;
  logic [W-1:0]   o_count;

  timeout_sched #(.N(N), .W(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_value  (value),
`ifdef TIMEOUT_SCHED_CANCEL_EN
    .i_cancel (cancel),
`endif
    .o_ack    (o_ack),
    .o_expire (o_expire),
    .o_busy   (o_busy),
    .o_owner  (o_owner),
    .o_count  (o_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: actual %0d required %0d",
               nm, cyc, act, exp);
    end
  endtask

  // Reference model: a granted timeout is described by its grant
  // edge and value; everything else follows from the elapsed time.
  bit         m_ok = 0;
  bit         m_run = 0;
  int         m_owner = 0;
  int         m_ptr = 0;
  int         m_v = 0;
  int         m_gt = 0;
  int         m_dl = 0;
  logic [N-1:0] e_ack = '0;
  logic [N-1:0] e_exp = '0;
  logic       e_busy = 0;
  int         e_count = 0;

  always @(posedge clk) begin
    int g;
    cyc++;
    m_ok  = 1;
    e_ack = '0;
    e_exp = '0;
    if (!rst_n) begin
      m_run = 0; m_owner = 0; m_ptr = 0; e_count = 0;
    end else if (m_run) begin
      if (cyc == m_dl) begin
        e_exp[m_owner] = 1'b1;
        m_run = 0;
        e_count = 0;
`ifdef TIMEOUT_SCHED_CANCEL_EN
      end else if (cancel[m_owner]) begin
        m_run = 0;
        e_count = 0;
`endif
      end else begin
        e_count = m_v - (cyc - m_gt);
      end
    end else if (|req) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      m_run   = 1;
      m_owner = g;
      m_v     = int'(value[g*W +: W]);
      m_gt    = cyc;
      m_dl    = cyc + m_v + 1;
      e_count = m_v;
      e_ack[g] = 1'b1;
      m_ptr   = (g + 1) % N;
    end
    e_busy = m_run;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("ack", o_ack, e_ack);
      chk("expire", o_expire, e_exp);
      chk("busy", o_busy, e_busy);
      chk("owner", o_owner, m_owner);
      chk("count", o_count, e_count);
    end
  end

  task automatic wait_pulse(input bit is_exp, input int ch,
                            input string nm, output int t);
    bit got;
    got = 0;
    t = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (is_exp ? o_expire[ch] : o_ack[ch]) begin
        got = 1;
        t = cyc;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s: actual no pulse in 60 cycles, required one", nm);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic idle_no_exp(input string nm, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (|o_expire) seen++;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    int ta, te, tp;
    repeat (2) @(negedge clk);
    chk("rst_ack", o_ack, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_count", o_count, 0);
    rst_n = 1;
    @(negedge clk);

    // single request, value 5
    value[2*W +: W] = 8'd5;
    req = 4'b0100;
    wait_pulse(0, 2, "t1_ack", ta);
    chk("t1_ack_vec", o_ack, 4'b0100);
    chk("t1_cnt", o_count, 5);
    req = '0;
    wait_pulse(1, 2, "t1_exp", te);
    chk("t1_delay", te - ta, 6);
    chk("t1_busy_at_exp", o_busy, 0);

    // value 0
    value[1*W +: W] = 8'd0;
    req = 4'b0010;
    wait_pulse(0, 1, "t2_ack", ta);
    req = '0;
    wait_pulse(1, 1, "t2_exp", te);
    chk("t2_delay", te - ta, 1);

    // all requesting, round-robin from pointer 0
    do_reset();
    for (int i = 0; i < N; i++) value[i*W +: W] = 8'd3;
    req = 4'b1111;
    tp = -1;
    for (int k = 0; k < 5; k++) begin
      wait_pulse(0, k % N, "t3_ack", ta);
      chk("t3_ack_vec", o_ack, 32'd1 << (k % N));
      if (k > 0) chk("t3_rearm_gap", ta - tp, 1);
      wait_pulse(1, k % N, "t3_exp", te);
      chk("t3_delay", te - ta, 4);
      tp = te;
    end
    req = '0;

    // reset during a run
    do_reset();
    value[0*W +: W] = 8'd10;
    req = 4'b0001;
    wait_pulse(0, 0, "t4_ack", ta);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("t4_busy", o_busy, 0);
    chk("t4_count", o_count, 0);
    chk("t4_owner", o_owner, 0);
    rst_n = 1;
    idle_no_exp("t4_no_exp", 20);

    // value changed while running
    value[3*W +: W] = 8'd4;
    req = 4'b1000;
    wait_pulse(0, 3, "t6_ack", ta);
    req = '0;
    value[3*W +: W] = 8'd9;
    wait_pulse(1, 3, "t6_exp", te);
    chk("t6_delay", te - ta, 5);

`ifdef TIMEOUT_SCHED_CANCEL_EN
    value[1*W +: W] = 8'd10;
    req = 4'b0010;
    wait_pulse(0, 1, "t5_ack", ta);
    req = '0;
    repeat (2) @(negedge clk);
    cancel = 4'b0010;
    @(negedge clk);
    cancel = '0;
    chk("t5_busy", o_busy, 0);
    chk("t5_count", o_count, 0);
    idle_no_exp("t5_no_exp", 20);
    value[2*W +: W] = 8'd2;
    req = 4'b0100;
    wait_pulse(0, 2, "t5b_ack", ta);
    req = '0;
    for (int k = 0; k < 10 && o_count != 0; k++) @(negedge clk);
    chk("t5b_cnt0", o_count, 0);
    cancel = 4'b0100;
    wait_pulse(1, 2, "t5b_exp", te);
    cancel = '0;
    chk("t5b_delay", te - ta, 3);
`endif

    // randomized traffic
    @(posedge clk);
    for (int c = 0; c < 4000; c++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && e_ack[i] && $urandom_range(0, 3) != 0) req[i] = 0;
        if (!req[i]) begin
          value[i*W +: W] = W'($urandom_range(0, 12));
          if ($urandom_range(0, 7) == 0) req[i] = 1;
        end
      end
      cancel = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 15)) : '0;
      rst_n = ($urandom_range(0, 299) != 0);
      @(posedge clk);
    end
    #1;
    rst_n = 1;
    req = '0;
    cancel = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
